// File: rtl/line_clear_engine.sv
// line_clear_engine: removes full rows from a locked game table, inserts pending
// garbage rows, writes the result back and reports attack lines and game over.
`timescale 1ns/1ps
module line_clear_engine #(
    parameter int COLS   = 10,
    parameter int ROWS   = 10,
    parameter int PEND_W = 4
) (
    input  logic                 clk_40M,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [COLS*ROWS-1:0] table_in,
    input  logic                 game_addLine,
    input  logic [3:0]           hole_col,
    output logic [COLS*ROWS-1:0] table_out,
    output logic                 table_we,
    output logic                 busy,
    output logic [2:0]           lines_cleared,
    output logic                 game_sendLine,
    output logic                 game_over
);
    localparam int RW = $clog2(ROWS);

    typedef enum logic [2:0] {IDLE, SCAN, SHIFT, GARBAGE, WRITE, SEND} state_t;

    state_t               state;
    logic [COLS*ROWS-1:0] work;
    logic [COLS*ROWS-1:0] shifted;
    logic [RW-1:0]        r;
    logic [2:0]           cnt;
    logic [PEND_W-1:0]    pending;
    logic [COLS-1:0]      new_row;
    logic [COLS-1:0]      garb;
    logic [3:0]           hole_idx;
    logic                 row_full;
    logic                 dec;

    assign row_full = &work[r*COLS +: COLS];
    assign dec      = (state == GARBAGE) && (pending != '0);
    assign hole_idx = (hole_col >= 4'(COLS)) ? 4'd0 : hole_col;

    // Rows 0..r-1 drop one row; the full row r is overwritten, row 0 empties.
    always_comb begin
        shifted = work;
        for (int i = 0; i < ROWS; i++) begin
            if (i == 0)
                shifted[0 +: COLS] = '0;
            else if (i <= int'(r))
                shifted[i*COLS +: COLS] = work[(i-1)*COLS +: COLS];
        end
    end

    // SHIFT judges the row that lands in r itself, so that row needs no rescan.
    assign new_row = shifted[r*COLS +: COLS];

    always_comb begin
        garb           = '1;
        garb[hole_idx] = 1'b0;
    end

    always_ff @(posedge clk_40M or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            work          <= '0;
            r             <= '0;
            cnt           <= '0;
            pending       <= '0;
            table_out     <= '0;
            table_we      <= 1'b0;
            busy          <= 1'b0;
            lines_cleared <= '0;
            game_sendLine <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            table_we <= 1'b0;
            if (game_addLine && !dec) begin
                if (pending != '1)
                    pending <= pending + 1'b1;
            end else if (dec && !game_addLine) begin
                pending <= pending - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        work  <= table_in;
                        r     <= RW'(ROWS-1);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (row_full)
                        state <= SHIFT;
                    else if (r == '0)
                        state <= GARBAGE;
                    else
                        r <= r - 1'b1;
                end
                SHIFT: begin
                    work <= shifted;
                    cnt  <= cnt + 3'd1;
                    if (&new_row)
                        state <= SHIFT;
                    else if (r == '0)
                        state <= GARBAGE;
                    else begin
                        r     <= r - 1'b1;
                        state <= SCAN;
                    end
                end
                GARBAGE: begin
                    if (pending != '0) begin
                        if (work[COLS-1:0] != '0)
                            game_over <= 1'b1;
                        work <= {garb, work[COLS*ROWS-1:COLS]};
                    end else begin
                        table_we      <= 1'b1;
                        table_out     <= work;
                        lines_cleared <= cnt;
                        state         <= WRITE;
                    end
                end
                WRITE: begin
                    busy  <= 1'b0;
                    state <= SEND;
                end
                SEND: begin
                    // cnt doubles as the remaining-pulse counter: cnt-1 pulses in total.
                    if (game_sendLine)
                        game_sendLine <= 1'b0;
                    else if (cnt >= 3'd2) begin
                        game_sendLine <= 1'b1;
                        cnt           <= cnt - 3'd1;
                    end else
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
